// File: rtl/ysyx_rf_pkg.sv
// ysyx_rf_pkg
// Shared defaults for the register file with scoreboard, plus the core-wide
// constants that other ysyx blocks already depend on.
//   RF_NR_REG / RF_DATA_W : default register count and width (RV32I)
//   REG_ZERO              : index of the hardwired-zero register
//   ysyx_W_WIDTH          : machine word width of the core
//   ysyx_PC_INIT          : reset value of the program counter
package ysyx_rf_pkg;

  localparam int RF_NR_REG = 32;
  localparam int RF_DATA_W = 32;
  localparam int REG_ZERO  = 0;

  localparam int ysyx_W_WIDTH = 32;
  localparam logic [ysyx_W_WIDTH-1:0] ysyx_PC_INIT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_rf_busy_cnt.sv
// ysyx_rf_busy_cnt
// Outstanding-write counter for one architectural register.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : one accepted issue targets this register
//   dec       : one bit per write-back port retiring a write to this register
//   clr       : flush, counter goes to zero next cycle
//   cnt       : current number of outstanding writes
//   sat       : counter is at its maximum, further issues must be refused
//   underflow : this cycle's decrements exceed the pending count (not in a flush)
module ysyx_rf_busy_cnt #(
  parameter int CNT_W = 2,
  parameter int NR_WB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [NR_WB-1:0] dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             underflow
);

  // Two spare bits hold cnt+1 and up to NR_WB (<=2) decrements without wrap.
  localparam int SW = CNT_W + 2;

  logic [SW-1:0] ndec;
  logic [SW-1:0] sum;

  always_comb begin
    ndec = '0;
    for (int p = 0; p < NR_WB; p++) begin
      ndec = ndec + SW'(dec[p]);
    end
  end

  assign sum       = SW'(cnt) + SW'(inc);
  assign sat       = (cnt == {CNT_W{1'b1}});
  assign underflow = !clr && (sum < ndec);

  // An over-retirement clamps at zero; the error itself is latched by the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sum < ndec) begin
      cnt <= '0;
    end else begin
      cnt <= CNT_W'(sum - ndec);
    end
  end

endmodule

// File: rtl/ysyx_regfile_sb.sv
// ysyx_regfile_sb
// Integer register file with per-register scoreboard of outstanding writes.
//   clk, rst     : clock, synchronous active-high reset
//   rd_addr      : NR_RD read addresses, port i at [i*AW +: AW]
//   rd_data      : NR_RD combinational read results (optionally bypassed)
//   rd_busy      : register still has writes in flight that the read cannot see
//   issue_valid  : an instruction writing issue_rd is issued
//   issue_rd     : its destination register
//   issue_ready  : issue can be accepted this cycle
//   wb_valid     : per write-back port, retire one outstanding write
//   wb_we        : per port, actually write the data (0 = cancelled write)
//   wb_addr      : per port destination
//   wb_data      : per port data
//   flush        : drop all outstanding-write tracking
//   err_o        : sticky, a write-back retired a write that was never issued
module ysyx_regfile_sb
  import ysyx_rf_pkg::*;
#(
  parameter int NR_REG = RF_NR_REG,
  parameter int DATA_W = RF_DATA_W,
  parameter int NR_RD  = 2,
  parameter int NR_WB  = 1,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NR_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_RD*AW-1:0]     rd_addr,
  output logic [NR_RD*DATA_W-1:0] rd_data,
  output logic [NR_RD-1:0]        rd_busy,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_ready,
  input  logic [NR_WB-1:0]        wb_valid,
  input  logic [NR_WB-1:0]        wb_we,
  input  logic [NR_WB*AW-1:0]     wb_addr,
  input  logic [NR_WB*DATA_W-1:0] wb_data,
  input  logic                    flush,
  output logic                    err_o
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DATA_W-1:0]           rf [NR_REG];
  logic [NR_REG-1:0][CNT_W-1:0] cnt;
  logic [NR_REG-1:0]           sat;
  logic [NR_REG-1:0]           udf;
  logic                        issue_fire;
  logic                        err_q;

  // x0 has no counter: it is never busy and never saturates.
  assign cnt[0] = '0;
  assign sat[0] = 1'b0;
  assign udf[0] = 1'b0;

  assign issue_ready = !flush && ((issue_rd == ZERO_ADDR) || !sat[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready;

  // One scoreboard counter per non-zero register.
  for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
    logic [NR_WB-1:0] dec;

    always_comb begin
      dec = '0;
      for (int p = 0; p < NR_WB; p++) begin
        dec[p] = wb_valid[p] && (wb_addr[p*AW +: AW] == AW'(i));
      end
    end

    ysyx_rf_busy_cnt #(
      .CNT_W (CNT_W),
      .NR_WB (NR_WB)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_fire && (issue_rd == AW'(i))),
      .dec       (dec),
      .clr       (flush),
      .cnt       (cnt[i]),
      .sat       (sat[i]),
      .underflow (udf[i])
    );
  end

  // Sticky error; underflow is already masked during flush by the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|udf) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  // Data array. Ports are applied in ascending order so the highest index
  // wins when two ports write the same register. Flush does not block writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NR_WB; p++) begin
        if (wb_valid[p] && wb_we[p] && (wb_addr[p*AW +: AW] != ZERO_ADDR)) begin
          rf[wb_addr[p*AW +: AW]] <= wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports. With bypass, same-cycle write-back data is forwarded and the
  // retiring write-backs count against the pending writes when judging busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NR_RD; r++) begin
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] d;
      logic [CNT_W+1:0]  nmatch;
      a      = rd_addr[r*AW +: AW];
      d      = rf[a];
      nmatch = '0;
      if ((BYPASS != 0) && (a != ZERO_ADDR)) begin
        for (int p = 0; p < NR_WB; p++) begin
          if (wb_valid[p] && (wb_addr[p*AW +: AW] == a)) begin
            nmatch = nmatch + 1'b1;
            if (wb_we[p]) begin
              d = wb_data[p*DATA_W +: DATA_W];
            end
          end
        end
      end
      rd_data[r*DATA_W +: DATA_W] = d;
      rd_busy[r] = (cnt[a] != '0) &&
                   ((BYPASS == 0) || (nmatch < {2'b00, cnt[a]}));
    end
  end

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
// tb_ysyx_regfile_sb
// Two instances (bypass on / off) share all inputs; a behavioural model of
// register contents, pending-write counts and the error flag predicts both.
module tb_ysyx_regfile_sb;

  localparam int NR_REG = 16;
  localparam int AW     = 4;
  localparam int DW     = 32;
  localparam int NR_RD  = 2;
  localparam int NR_WB  = 2;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 3;

  logic                 clk;
  logic                 rst;
  logic [NR_RD*AW-1:0]  rd_addr;
  logic [NR_RD*DW-1:0]  rd_data_bp, rd_data_nb;
  logic [NR_RD-1:0]     rd_busy_bp, rd_busy_nb;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_ready_bp, issue_ready_nb;
  logic [NR_WB-1:0]     wb_valid;
  logic [NR_WB-1:0]     wb_we;
  logic [NR_WB*AW-1:0]  wb_addr;
  logic [NR_WB*DW-1:0]  wb_data;
  logic                 flush;
  logic                 err_bp, err_nb;

  int checks;
  int failures;

  // Reference state: register values, pending writes, sticky error.
  logic [DW-1:0] mrf [NR_REG];
  int            mcnt[NR_REG];
  bit            merr;

  ysyx_regfile_sb #(
    .NR_REG (NR_REG), .DATA_W (DW), .NR_RD (NR_RD), .NR_WB (NR_WB),
    .CNT_W (CNT_W), .BYPASS (1), .AW (AW)
  ) dut_bp (
    .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_bp),
    .rd_busy (rd_busy_bp), .issue_valid (issue_valid), .issue_rd (issue_rd),
    .issue_ready (issue_ready_bp), .wb_valid (wb_valid), .wb_we (wb_we),
    .wb_addr (wb_addr), .wb_data (wb_data), .flush (flush), .err_o (err_bp)
  );

  ysyx_regfile_sb #(
    .NR_REG (NR_REG), .DATA_W (DW), .NR_RD (NR_RD), .NR_WB (NR_WB),
    .CNT_W (CNT_W), .BYPASS (0), .AW (AW)
  ) dut_nb (
    .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_nb),
    .rd_busy (rd_busy_nb), .issue_valid (issue_valid), .issue_rd (issue_rd),
    .issue_ready (issue_ready_nb), .wb_valid (wb_valid), .wb_we (wb_we),
    .wb_addr (wb_addr), .wb_data (wb_data), .flush (flush), .err_o (err_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NR_REG; i++) begin
      mrf[i]  = '0;
      mcnt[i] = 0;
    end
    merr = 1'b0;
  endtask

  // Drive one cycle of inputs at negedge, check the combinational outputs
  // against the model mid-cycle, then advance the model across the posedge.
  task automatic applyStimulus(input bit r, input bit iv, input logic [AW-1:0] ir,
                               input logic [1:0] wv, input logic [1:0] we,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input bit fl,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    logic [AW-1:0] wa[2];
    logic [DW-1:0] wd[2];
    logic [AW-1:0] ra[2];
    bit            exp_ready;
    int            nc[NR_REG];
    wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1; ra[0] = ra0; ra[1] = ra1;

    @(negedge clk);
    rst         = r;
    issue_valid = iv;
    issue_rd    = ir;
    wb_valid    = wv;
    wb_we       = we;
    wb_addr     = {a1, a0};
    wb_data     = {d1, d0};
    flush       = fl;
    rd_addr     = {ra1, ra0};
    #2;

    for (int p = 0; p < NR_RD; p++) begin
      logic [DW-1:0] ebp;
      int nm;
      ebp = mrf[ra[p]];
      nm  = 0;
      if (ra[p] != 0) begin
        for (int q = 0; q < NR_WB; q++) begin
          if (wv[q] && wa[q] == ra[p]) begin
            nm++;
            if (we[q]) ebp = wd[q];
          end
        end
      end
      checkOutput($sformatf("rd_data_bp[%0d]", p), rd_data_bp[p*DW +: DW], ebp);
      checkOutput($sformatf("rd_data_nb[%0d]", p), rd_data_nb[p*DW +: DW], mrf[ra[p]]);
      checkOutput($sformatf("rd_busy_bp[%0d]", p), DW'(rd_busy_bp[p]), DW'(mcnt[ra[p]] > nm));
      checkOutput($sformatf("rd_busy_nb[%0d]", p), DW'(rd_busy_nb[p]), DW'(mcnt[ra[p]] != 0));
    end
    exp_ready = !fl && (ir == 0 || mcnt[ir] < MAXC);
    checkOutput("issue_ready_bp", DW'(issue_ready_bp), DW'(exp_ready));
    checkOutput("issue_ready_nb", DW'(issue_ready_nb), DW'(exp_ready));
    checkOutput("err_bp", DW'(err_bp), DW'(merr));
    checkOutput("err_nb", DW'(err_nb), DW'(merr));

    @(posedge clk);
    if (r) begin
      modelReset();
    end else begin
      for (int q = 0; q < NR_WB; q++) begin
        if (wv[q] && we[q] && wa[q] != 0) mrf[wa[q]] = wd[q];
      end
      if (fl) begin
        for (int i = 0; i < NR_REG; i++) mcnt[i] = 0;
      end else begin
        for (int i = 0; i < NR_REG; i++) nc[i] = mcnt[i];
        if (iv && exp_ready && ir != 0) nc[ir]++;
        for (int q = 0; q < NR_WB; q++) begin
          if (wv[q] && wa[q] != 0) nc[wa[q]]--;
        end
        for (int i = 0; i < NR_REG; i++) begin
          if (nc[i] < 0) begin
            nc[i] = 0;
            merr  = 1'b1;
          end
          mcnt[i] = nc[i];
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; wb_valid = '0; wb_we = '0;
    wb_addr = '0; wb_data = '0; flush = 1'b0; rd_addr = '0;
    modelReset();
    repeat (2) @(posedge clk);

    // Reset state seen on x5 from both ports.
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 5, 5);
    checkOutput("reset_ready", DW'(issue_ready_bp), 32'd1);

    // Issue x5, write it back next cycle, read through and after.
    applyStimulus(0, 1, 5, 2'b00, 2'b00, 0, 0, 0, 0, 0, 5, 5);
    applyStimulus(0, 0, 0, 2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 5, 5);
    checkOutput("bypass_x5", rd_data_bp[DW-1:0], 32'hDEADBEEF);
    checkOutput("nobypass_busy_x5", DW'(rd_busy_nb[0]), 32'd1);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 5, 5);
    checkOutput("late_x5", rd_data_nb[DW-1:0], 32'hDEADBEEF);

    // Saturate x7, retire one, refill.
    repeat (3) applyStimulus(0, 1, 7, 2'b00, 2'b00, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 1, 7, 2'b00, 2'b00, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("sat_ready_x7", DW'(issue_ready_bp), 32'd0);
    applyStimulus(0, 0, 0, 2'b01, 2'b01, 7, 0, 32'h77, 0, 0, 7, 0);
    applyStimulus(0, 1, 7, 2'b00, 2'b00, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 1, 7, 2'b00, 2'b00, 0, 0, 0, 0, 0, 7, 0);

    // Two ports write x9 with two pending writes.
    repeat (2) applyStimulus(0, 1, 9, 2'b00, 2'b00, 0, 0, 0, 0, 0, 9, 9);
    applyStimulus(0, 0, 0, 2'b11, 2'b11, 9, 9, 32'h11, 32'h22, 0, 9, 9);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 9, 9);
    checkOutput("dual_wb_x9", rd_data_nb[DW-1:0], 32'h22);

    // Flush with concurrent write-back, then an orphan write-back.
    applyStimulus(0, 1, 3, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 4);
    applyStimulus(0, 1, 4, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 4);
    applyStimulus(0, 1, 6, 2'b01, 2'b01, 3, 0, 32'h55, 0, 1, 3, 4);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 4);
    checkOutput("flush_x3", rd_data_nb[DW-1:0], 32'h55);
    applyStimulus(0, 0, 0, 2'b01, 2'b01, 4, 0, 32'h66, 0, 0, 4, 7);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4, 7);
    checkOutput("err_sticky", DW'(err_bp), 32'd1);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4, 7);

    // x0 is immune to writes and issues.
    applyStimulus(0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 32'h1234, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_zero", rd_data_nb[DW-1:0], 32'd0);

    applyStimulus(1, 1, 5, 2'b01, 2'b01, 5, 0, 32'hABCD, 0, 0, 4, 5);

    // Randomized traffic; write-backs mostly target registers that are pending.
    for (int n = 0; n < 800; n++) begin
      int            rem[NR_REG];
      logic [1:0]    wv, we;
      logic [AW-1:0] wa[2];
      for (int i = 0; i < NR_REG; i++) rem[i] = mcnt[i];
      for (int p = 0; p < NR_WB; p++) begin
        wa[p] = AW'($urandom_range(0, 7));
        wv[p] = 1'b0;
        if (rem[wa[p]] > 0 && ($urandom % 4) != 0) begin
          wv[p] = 1'b1;
          rem[wa[p]]--;
        end else if (($urandom % 100) == 0) begin
          wv[p] = 1'b1;
        end
        we[p] = (($urandom % 4) != 0);
      end
      applyStimulus(($urandom % 64) == 0, $urandom % 2, AW'($urandom_range(0, 7)),
                    wv, we, wa[0], wa[1], $urandom, $urandom,
                    ($urandom % 20) == 0,
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
